// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Free-running video timing generator with built-in test patterns.
//   Produces vs/hs/de plus 8-bit RGB on the processing-chain stream interface.
//   The pattern select and enable are latched at the vsync leading edge, which
//   is v = V_ACTIVE+V_FP, h = 0.
//
// Ports
//   clock          in   pixel clock (only clock)
//   reset          in   synchronous, active-high reset
//   enable_i       in   0 = black frame, timing keeps running (latched per frame)
//   pattern_i[7:0] in   0 bars, 1 grey ramp, 2 checkerboard, 3 flat grey, else black
//   vs_o           out  vertical sync (polarity set by SYNC_POL)
//   hs_o           out  horizontal sync (polarity set by SYNC_POL)
//   de_o           out  data enable
//   rgb_r_o/g/b    out  pixel data, 0 outside de
//   frame_start_o  out  one-clock pulse on the first active pixel of a frame
//
// Build option
//   PATTERN_GEN_SCROLL_EN  adds an 8-bit per-frame offset to x for the ramp
//                          and checkerboard patterns (horizontal scroll).

module video_pattern_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_i,
    input  logic [7:0] pattern_i,
    output logic       vs_o,
    output logic       hs_o,
    output logic       de_o,
    output logic [7:0] rgb_r_o,
    output logic [7:0] rgb_g_o,
    output logic [7:0] rgb_b_o,
    output logic       frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [HW-1:0] px_q, px_d;
    logic [2:0]    bar_q, bar_d;
    logic [7:0]    pattern_q, pattern_d;
    logic          en_q, en_d;
`ifdef PATTERN_GEN_SCROLL_EN
    logic [7:0]    offset_q, offset_d;
`endif

    logic          de_q, hs_q, vs_q, fs_q;
    logic [7:0]    r_q, g_q, b_q;

    logic [31:0]   h_ext, v_ext;
    logic          h_wrap, latch;
    logic          de_c, hs_c, vs_c, fs_c;
    logic [7:0]    x_s;
    logic [7:0]    pix_r, pix_g, pix_b;

    always_comb begin
        h_ext  = 32'(h_q);
        v_ext  = 32'(v_q);
        h_wrap = (h_ext == H_TOTAL - 1);
        latch  = (v_ext == VS_BEG) && (h_ext == 0);

        h_d = h_wrap ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_wrap) begin
            v_d = (v_ext == V_TOTAL - 1) ? '0 : v_q + 1'b1;
        end

        // Bar position tracked by counters rather than a divider; the bar
        // counter saturates so the last bar absorbs any H_ACTIVE remainder.
        px_d  = px_q + 1'b1;
        bar_d = bar_q;
        if (h_wrap) begin
            px_d  = '0;
            bar_d = '0;
        end else if (32'(px_q) == BAR_W - 1) begin
            px_d  = '0;
            bar_d = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end

        pattern_d = latch ? pattern_i : pattern_q;
        en_d      = latch ? enable_i  : en_q;
`ifdef PATTERN_GEN_SCROLL_EN
        offset_d  = latch ? offset_q + 8'd1 : offset_q;
        x_s       = h_ext[7:0] + offset_q;
`else
        x_s       = h_ext[7:0];
`endif

        de_c = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        hs_c = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vs_c = (v_ext >= VS_BEG) && (v_ext < VS_END);
        fs_c = (h_ext == 0) && (v_ext == 0);

        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (de_c && en_q) begin
            case (pattern_q)
                8'd0: begin
                    // white, yellow, cyan, green, magenta, red, blue, black
                    pix_r = {8{~bar_q[1]}};
                    pix_g = {8{~bar_q[2]}};
                    pix_b = {8{~bar_q[0]}};
                end
                8'd1: begin
                    pix_r = x_s;
                    pix_g = x_s;
                    pix_b = x_s;
                end
                8'd2: begin
                    pix_r = {8{x_s[5] ^ v_ext[5]}};
                    pix_g = {8{x_s[5] ^ v_ext[5]}};
                    pix_b = {8{x_s[5] ^ v_ext[5]}};
                end
                8'd3: begin
                    pix_r = 8'h80;
                    pix_g = 8'h80;
                    pix_b = 8'h80;
                end
                default: begin
                    pix_r = '0;
                    pix_g = '0;
                    pix_b = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_q       <= '0;
            v_q       <= '0;
            px_q      <= '0;
            bar_q     <= '0;
            pattern_q <= '0;
            en_q      <= 1'b1;
`ifdef PATTERN_GEN_SCROLL_EN
            offset_q  <= '0;
`endif
            de_q      <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            fs_q      <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            px_q      <= px_d;
            bar_q     <= bar_d;
            pattern_q <= pattern_d;
            en_q      <= en_d;
`ifdef PATTERN_GEN_SCROLL_EN
            offset_q  <= offset_d;
`endif
            de_q      <= de_c;
            hs_q      <= hs_c ? SYNC_POL : ~SYNC_POL;
            vs_q      <= vs_c ? SYNC_POL : ~SYNC_POL;
            fs_q      <= fs_c;
            r_q       <= pix_r;
            g_q       <= pix_g;
            b_q       <= pix_b;
        end
    end

    assign de_o          = de_q;
    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign frame_start_o = fs_q;
    assign rgb_r_o       = r_q;
    assign rgb_g_o       = g_q;
    assign rgb_b_o       = b_q;

endmodule
